// File: rtl/sti_rx_unpack_pkg.sv
// Shared definitions for the serial receive/unpack block: frame length codes,
// code-to-bit-count mapping and FSM state encoding.
package sti_rx_unpack_pkg;

  localparam logic [1:0] LEN8  = 2'd0;
  localparam logic [1:0] LEN16 = 2'd1;
  localparam logic [1:0] LEN24 = 2'd2;
  localparam logic [1:0] LEN32 = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // 0->8, 1->16, 2->24, 3->32
  function automatic logic [5:0] len_bits(input logic [1:0] code);
    return {1'b0, code, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/sti_rx_unpack_if.sv
// Bus bundle of the unpacker: serial input stream, config, word result and
// the pixel-memory write port.
interface sti_rx_unpack_if #(parameter int ADDR_W = 8);
  // so_valid is a valid-only stream: every cycle with so_valid=1 carries one
  // bit that the receiver always takes (there is no ready); a frame is a
  // contiguous run of so_valid=1 and ends on the first so_valid=0 cycle.
  logic              so_data;
  logic              so_valid;
  logic [1:0]        cfg_length;
  logic              cfg_msb;
  logic [31:0]       rx_data;
  logic              rx_valid;
  logic              rx_err;
  logic [7:0]        frame_cnt;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_dataout;
  logic              mem_finish;

  modport master (
    output so_data, so_valid, cfg_length, cfg_msb,
    input  rx_data, rx_valid, rx_err, frame_cnt,
    input  mem_wr, mem_addr, mem_dataout, mem_finish
  );

  modport slave (
    input  so_data, so_valid, cfg_length, cfg_msb,
    output rx_data, rx_valid, rx_err, frame_cnt,
    output mem_wr, mem_addr, mem_dataout, mem_finish
  );
endinterface

// File: rtl/sti_byte_writer.sv
// Packs captured bits into bytes (first bit -> bit 7) and writes them to
// sequential addresses, stopping for good once the last address is written.
module sti_byte_writer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_bit_stb,
  input  logic              i_bit,
  input  logic              i_frame_start,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_dataout,
  output logic              o_mem_finish
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [2:0]        r_bcnt;
  logic [6:0]        r_hist;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_dout;
  logic              r_finish;

  // A frame start discards any partial byte left over from the previous frame.
  logic [2:0] w_cnt;
  logic [6:0] w_hist;
  logic       w_full;
  assign w_cnt  = i_frame_start ? 3'd0 : r_bcnt;
  assign w_hist = i_frame_start ? 7'd0 : r_hist;
  assign w_full = i_bit_stb && (w_cnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcnt   <= '0;
      r_hist   <= '0;
      r_mem_wr <= 1'b0;
      r_addr   <= '0;
      r_dout   <= '0;
      r_finish <= 1'b0;
    end else begin
      r_mem_wr <= 1'b0;
      if (i_bit_stb) begin
        r_hist <= {w_hist[5:0], i_bit};
        r_bcnt <= w_cnt + 3'd1;
      end
      if (w_full && !r_finish) begin
        r_mem_wr <= 1'b1;
        r_dout   <= {w_hist, i_bit};
        if (r_addr == LAST_ADDR) r_finish <= 1'b1;
      end
      // Advance one edge after the strobe; the last address is never left.
      if (r_mem_wr && !r_finish) r_addr <= r_addr + 1'b1;
    end
  end

  assign o_mem_wr      = r_mem_wr;
  assign o_mem_addr    = r_addr;
  assign o_mem_dataout = r_dout;
  assign o_mem_finish  = r_finish;
endmodule

// File: rtl/sti_rx_unpack.sv
// Serial receiver: rebuilds each frame into a word of the configured length and
// bit order, flags bad bit counts and streams all captured bits to memory.
module sti_rx_unpack
  import sti_rx_unpack_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  sti_rx_unpack_if.slave        bus,
  output state_e                o_dbg_state
);
  state_e      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [5:0]  r_len;
  logic        r_msb;
  logic [31:0] r_word;
  logic [31:0] r_rx_data;
  logic        r_rx_valid;
  logic        r_rx_err;
  logic [7:0]  r_frame_cnt;

  logic w_start, w_capture, w_good, w_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.so_valid) w_next = S_SHIFT;
      S_SHIFT: if (!bus.so_valid)        w_next = S_IDLE;
               else if (r_cnt == 6'd32)  w_next = S_DRAIN;
      S_DRAIN: if (!bus.so_valid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A bit arriving with 32 already held is an overrun and is not captured.
  always_comb begin
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_good    = 1'b0;
    w_bad     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start   = bus.so_valid;
        w_capture = bus.so_valid;
      end
      S_SHIFT: begin
        w_capture = bus.so_valid && (r_cnt != 6'd32);
        w_good    = !bus.so_valid && (r_cnt == r_len);
        w_bad     = !bus.so_valid && (r_cnt != r_len);
      end
      S_DRAIN: w_bad = !bus.so_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_len       <= '0;
      r_msb       <= 1'b0;
      r_word      <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_err    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_rx_valid <= w_good;
      r_rx_err   <= w_bad;
      if (w_start) begin
        r_len  <= len_bits(bus.cfg_length);
        r_msb  <= bus.cfg_msb;
        r_word <= {31'd0, bus.so_data};
        r_cnt  <= 6'd1;
      end else if (w_capture) begin
        if (r_msb) r_word <= {r_word[30:0], bus.so_data};
        else       r_word[r_cnt[4:0]] <= bus.so_data;
        r_cnt <= r_cnt + 6'd1;
      end
      if (w_good) begin
        r_rx_data   <= r_word;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  sti_byte_writer #(.ADDR_W(ADDR_W)) u_byte_writer (
    .clk           (clk),
    .reset         (reset),
    .i_bit_stb     (w_capture),
    .i_bit         (bus.so_data),
    .i_frame_start (w_start),
    .o_mem_wr      (bus.mem_wr),
    .o_mem_addr    (bus.mem_addr),
    .o_mem_dataout (bus.mem_dataout),
    .o_mem_finish  (bus.mem_finish)
  );

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.rx_err    = r_rx_err;
  assign bus.frame_cnt = r_frame_cnt;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_sti_rx_unpack.sv
// Self-checking bench for sti_rx_unpack: directed frame table plus hand-written
// latency, memory-fill and mid-frame-reset sequences.
module tb_sti_rx_unpack;
  import sti_rx_unpack_pkg::*;

  logic   clk;
  logic   reset;
  state_e dbg_state;

  sti_rx_unpack_if #(.ADDR_W(8)) bus ();

  sti_rx_unpack #(.ADDR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: expected and observed memory writes as {addr, data}
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [7:0]  exp_addr;
  logic        exp_fin;
  logic [7:0]  exp_fc;
  logic [31:0] exp_rx;

  int  n_valid, n_err, n_wide, n_coinc;
  logic prev_valid, prev_err;

  always @(negedge clk) begin
    if (bus.mem_wr) obs_q.push_back({bus.mem_addr, bus.mem_dataout});
    if (bus.rx_valid) n_valid++;
    if (bus.rx_err) n_err++;
    if ((bus.rx_valid && prev_valid) || (bus.rx_err && prev_err)) n_wide++;
    if (bus.rx_valid && bus.mem_wr) n_coinc++;
    prev_valid = bus.rx_valid;
    prev_err   = bus.rx_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.so_valid = 1'b0;
    bus.so_data = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_addr = 8'd0; exp_fin = 1'b0; exp_fc = 8'd0; exp_rx = 32'd0;
  endtask

  // Model of byte packing: only the first 32 bits of a frame are captured.
  task automatic model_frame(input logic [63:0] word, input int nbits, input logic msb);
    logic [7:0] b;
    int cap;
    b = 8'd0;
    cap = (nbits > 32) ? 32 : nbits;
    for (int i = 0; i < cap; i++) begin
      b = {b[6:0], (msb ? word[nbits-1-i] : word[i])};
      if ((i % 8) == 7 && !exp_fin) begin
        exp_q.push_back({exp_addr, b});
        if (exp_addr == 8'hFF) exp_fin = 1'b1;
        else exp_addr = exp_addr + 8'd1;
      end
    end
  endtask

  // Driver: config is scrambled after the first bit to prove it is latched once.
  task automatic send_frame(input logic [63:0] word, input int nbits,
                            input logic [1:0] len, input logic msb);
    bus.cfg_length = len;
    bus.cfg_msb = msb;
    for (int i = 0; i < nbits; i++) begin
      bus.so_valid = 1'b1;
      bus.so_data = msb ? word[nbits-1-i] : word[i];
      @(posedge clk); #1;
      if (i == 0) begin
        bus.cfg_length = ~len;
        bus.cfg_msb = ~msb;
      end
    end
    bus.so_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare_mem(input string name);
    check({name, "_wr_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({name, "_wr"}, {16'd0, obs_q[i]}, {16'd0, exp_q[i]});
    obs_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [63:0] word;
    int          nbits;
    logic [1:0]  len;
    logic        msb;
    logic        rst_before;
    logic        exp_good;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int v0, e0;
    logic [31:0] w;
    bus.cfg_length = LEN8;
    bus.cfg_msb = 1'b1;
    prev_valid = 1'b0;
    prev_err = 1'b0;
    n_valid = 0; n_err = 0; n_wide = 0; n_coinc = 0;
    do_reset();

    // reset values
    check("rst_rx_data", bus.rx_data, 32'd0);
    check("rst_flags", {28'd0, bus.rx_valid, bus.rx_err, bus.mem_wr, bus.mem_finish}, 32'd0);
    check("rst_frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
    check("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_data", {24'd0, bus.mem_dataout}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // LEN8 MSB-first 0xA5 with cycle-exact timing
    bus.cfg_length = LEN8;
    bus.cfg_msb = 1'b1;
    w = 32'hA5;
    for (int i = 0; i < 8; i++) begin
      bus.so_valid = 1'b1;
      bus.so_data = w[7-i];
      @(posedge clk); #1;
    end
    bus.so_valid = 1'b0;
    @(negedge clk);
    check("a5_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
    check("a5_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    check("a5_mem_data", {24'd0, bus.mem_dataout}, 32'hA5);
    check("a5_no_early_valid", {31'd0, bus.rx_valid}, 32'd0);
    @(negedge clk);
    check("a5_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
    check("a5_rx_data", bus.rx_data, 32'hA5);
    check("a5_frame_cnt", {24'd0, bus.frame_cnt}, 32'd1);
    check("a5_addr_incr", {24'd0, bus.mem_addr}, 32'd1);
    @(negedge clk);
    check("a5_valid_1cyc", {31'd0, bus.rx_valid}, 32'd0);
    @(posedge clk); #1;

    // table: word, nbits, len, msb, reset before, good frame
    vecs[0] = '{64'h00000000_000000A5,  8, LEN8,  1'b1, 1'b1, 1'b1};
    vecs[1] = '{64'h00000000_00001234, 16, LEN16, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{64'h00000000_00000ABC, 12, LEN16, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{64'h000000A1_B2C3D4E5, 40, LEN32, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{64'h00000000_0000003C,  8, LEN8,  1'b1, 1'b0, 1'b1};
    vecs[5] = '{64'h00000000_00C0FFEE, 24, LEN24, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{64'h00000000_0000BEEF, 16, LEN8,  1'b1, 1'b0, 1'b0};
    vecs[7] = '{64'h00000000_DEADBEEF, 32, LEN32, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{64'h00000000_0000017F,  9, LEN8,  1'b0, 1'b0, 1'b0};

    for (int k = 0; k < 9; k++) begin
      if (vecs[k].rst_before) do_reset();
      obs_q.delete();
      exp_q.delete();
      v0 = n_valid;
      e0 = n_err;
      model_frame(vecs[k].word, vecs[k].nbits, vecs[k].msb);
      if (vecs[k].exp_good) begin
        exp_rx = vecs[k].word[31:0];
        exp_fc = exp_fc + 8'd1;
      end
      send_frame(vecs[k].word, vecs[k].nbits, vecs[k].len, vecs[k].msb);
      check($sformatf("v%0d_rx_valid_cnt", k), n_valid - v0, {31'd0, vecs[k].exp_good});
      check($sformatf("v%0d_rx_err_cnt", k), n_err - e0, {31'd0, ~vecs[k].exp_good});
      check($sformatf("v%0d_rx_data", k), bus.rx_data, exp_rx);
      check($sformatf("v%0d_frame_cnt", k), {24'd0, bus.frame_cnt}, {24'd0, exp_fc});
      compare_mem($sformatf("v%0d", k));
    end

    // fill memory: 64 LEN32 frames = 256 bytes
    do_reset();
    obs_q.delete();
    for (int k = 0; k < 64; k++) begin
      w = $urandom;
      model_frame({32'd0, w}, 32, 1'b1);
      send_frame({32'd0, w}, 32, LEN32, 1'b1);
      if (k == 62) check("fill_not_finished", {31'd0, bus.mem_finish}, 32'd0);
    end
    check("fill_finish", {31'd0, bus.mem_finish}, 32'd1);
    check("fill_addr_hold", {24'd0, bus.mem_addr}, 32'hFF);
    check("fill_frame_cnt", {24'd0, bus.frame_cnt}, 32'd64);
    compare_mem("fill");
    v0 = n_valid;
    w = $urandom;
    send_frame({32'd0, w}, 32, LEN32, 1'b1);
    check("post_fill_valid", n_valid - v0, 32'd1);
    check("post_fill_rx_data", bus.rx_data, w);
    check("post_fill_no_wr", obs_q.size(), 32'd0);
    check("post_fill_finish_sticky", {31'd0, bus.mem_finish}, 32'd1);
    obs_q.delete();

    // reset after 5 bits of a LEN8 frame
    bus.cfg_length = LEN8;
    bus.cfg_msb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.so_valid = 1'b1;
      bus.so_data = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    bus.so_valid = 1'b0;
    #1;
    check("midrst_rx_data", bus.rx_data, 32'd0);
    check("midrst_frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
    check("midrst_mem", {bus.mem_finish, bus.mem_wr, 14'd0, bus.mem_dataout, bus.mem_addr}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    @(posedge clk); #1;
    reset = 1'b0;
    exp_addr = 8'd0; exp_fin = 1'b0; exp_fc = 8'd0; exp_rx = 32'd0;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back({8'd0, 8'hFF});
    send_frame(64'hFF, 8, LEN8, 1'b1);
    check("midrst_next_rx_data", bus.rx_data, 32'hFF);
    check("midrst_next_frame_cnt", {24'd0, bus.frame_cnt}, 32'd1);
    compare_mem("midrst_next");

    // whole-run pulse properties
    check("pulse_width", n_wide, 32'd0);
    check("valid_wr_coincide", n_coinc, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
